// File: rtl/mips_avalon_ram_slave.sv
// Avalon-MM slave RAM for the MIPS bus CPU: one word-addressed window at BASE_ADDR,
// a fixed stall per access, byte-lane writes and a sticky illegal-access flag.
module mips_avalon_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        access_error
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_BAD   = 2'd3
    } op_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    op_t         op_q, op_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic                  req_s;
    op_t                   in_op_s;
    op_t                   cur_op_s;
    logic [31:0]           cur_addr_s;
    logic [31:0]           offset_s;
    logic                  in_window_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [31:0]           mem_word_s;
    logic [31:0]           ack_rdata_s;
    logic                  mem_we_s;

    // Decode the incoming request and select the address/op of the access in flight.
    always_comb begin
        req_s = read | write;
        if (read && write) begin
            in_op_s = OP_BAD;
        end else if (read) begin
            in_op_s = OP_READ;
        end else if (write) begin
            in_op_s = OP_WRITE;
        end else begin
            in_op_s = OP_NONE;
        end
        if (state_q == ST_IDLE) begin
            cur_addr_s = address;
            cur_op_s   = in_op_s;
        end else begin
            cur_addr_s = addr_q;
            cur_op_s   = op_q;
        end
        offset_s    = cur_addr_s - BASE_ADDR;
        in_window_s = ((offset_s >> (ADDR_WIDTH + 2)) == 32'd0);
        word_idx_s  = offset_s[ADDR_WIDTH+1:2];
        mem_word_s  = mem[word_idx_s];
        mem_we_s    = (state_q == ST_ACK) && (op_q == OP_WRITE) && in_window_s;
    end

    // Value loaded into readdata when an access reaches ACK; writes keep the old value.
    always_comb begin
        if (cur_op_s == OP_READ) begin
            if (in_window_s) begin
                ack_rdata_s = mem_word_s;
            end else begin
                ack_rdata_s = 32'h0;
            end
        end else if (cur_op_s == OP_BAD) begin
            ack_rdata_s = 32'h0;
        end else begin
            ack_rdata_s = rdata_q;
        end
    end

    // Handshake FSM. The request cycle itself is the first stall cycle, so a
    // single-cycle stall skips WAIT and the WAIT leg spans WAIT_CYCLES-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = byteenable;
                    op_d    = in_op_s;
                    cnt_d   = CNT_INIT;
                    if ((in_op_s == OP_BAD) || !in_window_s || (address[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (CNT_INIT == 4'd0) begin
                        state_d = ST_ACK;
                        rdata_d = ack_rdata_s;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                    rdata_d = ack_rdata_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            op_q    <= OP_NONE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM array is never reset; a write lands on the ACK edge only.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[word_idx_s] <= merge_lanes(mem_word_s, wdata_q, be_q);
        end
    end

    assign waitrequest  = reset & req_s & (state_q != ST_ACK);
    assign readdata     = rdata_q;
    assign access_error = err_q;

endmodule

// File: tb/tb_mips_avalon_ram_slave.sv
// Bench for mips_avalon_ram_slave: one instance with a 1-cycle stall, one with 3.
module tb_mips_avalon_ram_slave;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_i  [2];
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] wdata_i [2];
    logic [3:0]  be_i    [2];
    logic        wait_o  [2];
    logic [31:0] rdata_o [2];
    logic        err_o   [2];

    int nerr = 0;
    int nchk = 0;

    logic [31:0] mref  [2][WORDS];
    logic        mflag [2];
    logic [31:0] mrd   [2];
    int          wcyc  [2];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    mips_avalon_ram_slave #(.WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .address(addr_i[0]), .read(rd_i[0]), .write(wr_i[0]),
        .writedata(wdata_i[0]), .byteenable(be_i[0]), .waitrequest(wait_o[0]),
        .readdata(rdata_o[0]), .access_error(err_o[0])
    );

    mips_avalon_ram_slave #(.WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(rst_n), .address(addr_i[1]), .read(rd_i[1]), .write(wr_i[1]),
        .writedata(wdata_i[1]), .byteenable(be_i[1]), .waitrequest(wait_o[1]),
        .readdata(rdata_o[1]), .access_error(err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Behavioural memory: window test by plain arithmetic, byte lanes merged one by one.
    task automatic model(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        longint off;
        bit     ok;
        int     idx;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        ok  = (off >= 0) && (off < 4 * WORDS);
        idx = ok ? int'(off / 4) : 0;
        if ((r && w) || !ok || (a % 4 != 0)) mflag[d] = 1'b1;
        if (r && w) begin
            mrd[d] = 32'h0;
        end else if (r) begin
            mrd[d] = ok ? mref[d][idx] : 32'h0;
        end else if (w && ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mref[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic bus(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        @(negedge clk);
        rd_i[d] = r; wr_i[d] = w; addr_i[d] = a; wdata_i[d] = wd; be_i[d] = be;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (!wait_o[d]) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        rd = rdata_o[d];
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL timeout: waitrequest still high after %0d cycles, required low", stalls);
        end
        @(posedge clk);
        #1;
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input string tag);
        logic [31:0] got;
        int          st;
        bus(d, r, w, a, wd, be, got, st);
        model(d, r, w, a, wd, be);
        check({tag, "_rdata"}, got, mrd[d]);
        check({tag, "_stall"}, 32'(st), 32'(wcyc[d]));
        check({tag, "_err"}, {31'h0, err_o[d]}, {31'h0, mflag[d]});
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] old;
        int          st;
        int          d;
        int          k;
        int          sel;
        int          t;

        wcyc[0] = 1;
        wcyc[1] = 3;
        for (int i = 0; i < 2; i++) begin
            addr_i[i] = 32'h0; rd_i[i] = 1'b0; wr_i[i] = 1'b0;
            wdata_i[i] = 32'h0; be_i[i] = 4'h0;
            mflag[i] = 1'b0; mrd[i] = 32'h0;
        end

        // Reset low for three cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_wait", {31'h0, wait_o[i]}, 32'h0);
            check("reset_rdata", rdata_o[i], 32'h0);
            check("reset_err", {31'h0, err_o[i]}, 32'h0);
        end

        // Directed vectors on the 1-cycle-stall instance.
        tbl[0] = '{1'b0, 1'b1, 32'hBFC00000, 32'h24020005, 4'hF, 32'h00000000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'hBFC00000, 32'h00000000, 4'hF, 32'h24020005, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, 32'h24020005, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'hBFC00010, 32'h11223344, 4'b0101, 32'h24020005, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'hBFC00010, 32'h00000000, 4'hF, 32'hDE22BE44, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'hBFC00010, 32'hFFFFFFFF, 4'b0000, 32'hDE22BE44, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'hBFC00010, 32'h00000000, 4'hF, 32'hDE22BE44, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'hBFC00000, 32'h00000000, 4'hF, 32'h24020005, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, got, st);
            model(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be);
            check($sformatf("vec%0d_rdata", i), got, tbl[i].exp_rd);
            check($sformatf("vec%0d_stall", i), 32'(st), 32'd1);
            check($sformatf("vec%0d_err", i), {31'h0, err_o[0]}, {31'h0, tbl[i].exp_err});
        end

        // Out-of-window read, then read and write together.
        bus(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'hF, got, st);
        model(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'hF);
        check("oow_rdata", got, 32'h0);
        check("oow_err", {31'h0, err_o[0]}, 32'h1);
        bus(0, 1'b1, 1'b1, 32'hBFC00010, 32'h0, 4'hF, got, st);
        model(0, 1'b1, 1'b1, 32'hBFC00010, 32'h0, 4'hF);
        check("rw_rdata", got, 32'h0);
        check("rw_err", {31'h0, err_o[0]}, 32'h1);
        bus(0, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, got, st);
        model(0, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF);
        check("rw_nochange", got, 32'hDE22BE44);

        // Fill a 16-word region of both instances, then random traffic.
        for (int dd = 0; dd < 2; dd++) begin
            for (int w = 0; w < 16; w++) begin
                xfer(dd, 1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, "fill");
            end
        end
        for (int n = 0; n < 160; n++) begin
            d   = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 15));
            sel = int'($urandom_range(0, 9));
            if (sel < 8) begin
                a = BASE + 32'(4 * k);
            end else if (sel == 8) begin
                a = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h00000000;
                    1:       a = BASE - 32'd4;
                    default: a = BASE + 32'd4096 + 32'(4 * k);
                endcase
            end
            t = int'($urandom_range(0, 19));
            xfer(d, (t < 9) || (t >= 18), (t >= 9), a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        // Write dropped during WAIT on the 3-cycle instance: memory untouched.
        old = mref[1][2];
        @(negedge clk);
        rd_i[1] = 1'b0; wr_i[1] = 1'b1; addr_i[1] = BASE + 32'd8; wdata_i[1] = ~old; be_i[1] = 4'hF;
        #1;
        check("abort_wait_hi", {31'h0, wait_o[1]}, 32'h1);
        @(negedge clk);
        wr_i[1] = 1'b0;
        #1;
        check("abort_wait_lo", {31'h0, wait_o[1]}, 32'h0);
        xfer(1, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'hF, "abort_wr");
        check("abort_wr_word", mrd[1], old);

        // Read dropped during WAIT: readdata keeps its last value.
        @(negedge clk);
        rd_i[1] = 1'b1; addr_i[1] = BASE + 32'd12;
        @(negedge clk);
        rd_i[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_rd_hold", rdata_o[1], mrd[1]);

        // Back-to-back reads with the request held: one idle cycle between accepts.
        @(negedge clk);
        rd_i[0] = 1'b1; wr_i[0] = 1'b0; addr_i[0] = BASE + 32'd20;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("b2b_wait%0d", c), {31'h0, wait_o[0]}, (c % 2 == 0) ? 32'h1 : 32'h0);
            if (c % 2 == 1) check($sformatf("b2b_rdata%0d", c), rdata_o[0], mref[0][5]);
            @(negedge clk);
        end
        rd_i[0] = 1'b0;
        mrd[0]  = mref[0][5];

        // Reset during WAIT of a write: write dropped, waitrequest low at once.
        old = mref[1][5];
        @(negedge clk);
        wr_i[1] = 1'b1; addr_i[1] = BASE + 32'd20; wdata_i[1] = ~old; be_i[1] = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wait", {31'h0, wait_o[1]}, 32'h0);
        wr_i[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mflag[i] = 1'b0;
            mrd[i]   = 32'h0;
        end
        #1;
        check("rst_mid_err", {31'h0, err_o[1]}, 32'h0);
        check("rst_mid_rdata", rdata_o[1], 32'h0);
        xfer(1, 1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'hF, "rst_mid_rd");
        check("rst_mid_word", mrd[1], old);

        // Misaligned read after reset: aligned-down word, flag raised.
        xfer(1, 1'b1, 1'b0, BASE + 32'd14, 32'h0, 4'hF, "misalign");
        check("misalign_err", {31'h0, err_o[1]}, 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
